crypt_round_sequencer: RTL and testbench

//  Round-level controller for the CRYPT byte cipher. Drives the step strobe of the key

---
 rtl/crypt_pkg.sv | 14 +
 rtl/crypt_step_pulser.sv | 13 +
 rtl/crypt_round_sequencer.sv | 84 ++++++++
 tb/tb_crypt_round_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_pkg.sv
// crypt_pkg: shared state encoding and widths for the CRYPT round sequencer
package crypt_pkg;
    localparam int KEY_W = 8;
    localparam int RND_W = 7;
    localparam int CNT_W = 8;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STEP,
        ST_SETTLE,
        ST_PRESENT,
        ST_FINISH
    } state_t;
endpackage

// File: rtl/crypt_step_pulser.sv
// crypt_step_pulser: registered one-cycle scheduler strobe with an enforced low cycle between strobes
module crypt_step_pulser (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic sched_step,
    output logic gap_ok
);
    assign gap_ok = ~sched_step;
    always_ff @(posedge clk or posedge rst)
        if (rst) sched_step <= 1'b0;
        else sched_step <= req & gap_ok;
endmodule

// File: rtl/crypt_round_sequencer.sv
// crypt_round_sequencer: steps the key scheduler and hands settled round keys to the datapath once per round
module crypt_round_sequencer
    import crypt_pkg::*;
#(
    parameter int NUM_ROUNDS    = 16,
    parameter int PRIME_STEPS   = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] k0_in,
    input  logic [KEY_W-1:0] k1_in,
    input  logic [KEY_W-1:0] k2_in,
    output logic             sched_step,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk0,
    output logic [KEY_W-1:0] rk1,
    output logic [KEY_W-1:0] rk2,
    output logic [RND_W-1:0] round_idx,
    output logic             busy,
    output logic             done
);
    state_t state, state_next;
    logic [CNT_W-1:0] prime_cnt;
    logic [1:0] settle_cnt;
    logic gap_ok, req, prime_req, handshake, last;

    assign handshake = state == ST_PRESENT && rk_ready;
    assign last = round_idx == RND_W'(NUM_ROUNDS);
    assign prime_req = state == ST_PRIME && prime_cnt != '0 && gap_ok && !abort;
    // the strobe register is loaded on the way into STEP so the strobe lines up with the STEP cycle
    assign req = prime_req || state_next == ST_STEP;

    crypt_step_pulser u_pulser (
        .clk(clk),
        .rst(rst),
        .req(req),
        .sched_step(sched_step),
        .gap_ok(gap_ok)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        if (abort) state_next = ST_IDLE;
        else case (state)
            ST_IDLE:    state_next = start ? (PRIME_STEPS == 0 ? ST_STEP : ST_PRIME) : ST_IDLE;
            ST_PRIME:   state_next = (prime_cnt == '0 && gap_ok) ? ST_STEP : ST_PRIME;
            ST_STEP:    state_next = ST_SETTLE;
            ST_SETTLE:  state_next = settle_cnt == 2'd1 ? ST_PRESENT : ST_SETTLE;
            ST_PRESENT: state_next = handshake ? (last ? ST_FINISH : ST_STEP) : ST_PRESENT;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rk_valid = state == ST_PRESENT;
        busy = state != ST_IDLE;
        done = state == ST_FINISH;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prime_cnt <= '0;
            settle_cnt <= '0;
            round_idx <= '0;
            rk0 <= '0;
            rk1 <= '0;
            rk2 <= '0;
        end else begin
            if (state == ST_IDLE && start) prime_cnt <= CNT_W'(PRIME_STEPS);
            else if (prime_req) prime_cnt <= prime_cnt - 1'b1;
            settle_cnt <= state == ST_STEP ? 2'(SETTLE_CYCLES) : state == ST_SETTLE ? settle_cnt - 2'd1 : settle_cnt;
            if (state == ST_SETTLE && state_next == ST_PRESENT) {rk0, rk1, rk2} <= {k0_in, k1_in, k2_in};
            round_idx <= state_next == ST_STEP ? (state == ST_PRESENT ? round_idx + 1'b1 : RND_W'(1))
                       : (state_next == ST_IDLE || state_next == ST_FINISH) ? '0 : round_idx;
        end
endmodule

// File: tb/tb_crypt_round_sequencer.sv
// tb_crypt_round_sequencer: randomized-key bench with a behavioural key scheduler and closed-form key model
module tb_crypt_round_sequencer;
    localparam int N = 4;
    localparam int P = 2;
    localparam int S = 2;

    logic clk = 0, rst = 0, start = 0, abort = 0, rk_ready = 0;
    logic [7:0] k0_in, k1_in, k2_in, rk0, rk1, rk2;
    logic sched_step, rk_valid, busy, done;
    logic [6:0] round_idx;
    int compared = 0, mismatched = 0;
    int exp_steps = 0;

    always #5 clk = ~clk;

    crypt_round_sequencer #(.NUM_ROUNDS(N), .PRIME_STEPS(P), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .k0_in(k0_in), .k1_in(k1_in), .k2_in(k2_in),
        .sched_step(sched_step), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk0(rk0), .rk1(rk1), .rk2(rk2),
        .round_idx(round_idx), .busy(busy), .done(done)
    );

    // scheduler: steps on a rising flag, never rewound by the sequencer's reset or abort
    logic [6:0] cnt = 7'd1;
    logic [7:0] key = 8'h00, k1m = 8'h00, k2m = 8'h00;
    logic prev = 0;
    int strobes = 0, back_to_back = 0;
    assign k0_in = {1'b0, cnt} ^ key;
    assign k1_in = k1m;
    assign k2_in = k2m;
    always @(posedge clk) begin
        if (sched_step && prev) back_to_back++;
        if (sched_step && !prev) begin
            strobes++;
            cnt <= cnt + 7'd1;
            k1m <= k0_in;
            k2m <= k1m;
        end
        prev <= sched_step;
    end

    int cyc = 0, done_n = 0, done_at = 0;
    int hs_cyc[$];
    logic [6:0] hs_rnd[$];
    logic [23:0] hs_key[$];
    always @(negedge clk) begin
        cyc++;
        if (rk_valid && rk_ready && !abort && !rst) begin
            hs_cyc.push_back(cyc);
            hs_rnd.push_back(round_idx);
            hs_key.push_back({rk0, rk1, rk2});
        end
        if (done) begin
            done_n++;
            done_at = cyc;
        end
    end

    // K_0 once the scheduler counter holds c: counter starts at 1 and wraps at 7 bits
    function automatic logic [7:0] kf(int c);
        return {1'b0, 7'(c)} ^ key;
    endfunction

    function automatic logic [23:0] exp_key(int base, int n);
        int s = base + P + n;
        return {kf(s + 1), kf(s), kf(s - 1)};
    endfunction

    task automatic clear_logs();
        hs_cyc.delete();
        hs_rnd.delete();
        hs_key.delete();
        done_n = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); #1 ok = !busy;
        end
    endtask

    task automatic wait_for(input logic [6:0] r, input logic v, output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); #1 ok = (round_idx == r) && (rk_valid == v);
        end
    endtask

    task automatic test_reset();
        rst = 1; #1;
        compared++;
        if ({sched_step, rk_valid, busy, done, round_idx} !== 11'h0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %h want 0", {sched_step, rk_valid, busy, done, round_idx});
        end
        compared++;
        if ({rk0, rk1, rk2} !== 24'h0) begin
            mismatched++;
            $display("FAIL reset_keys: got %h want 0", {rk0, rk1, rk2});
        end
        @(posedge clk); #1 rst = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int base = exp_steps, s0 = strobes;
        clear_logs();
        rk_ready = 1;
        pulse_start();
        wait_idle(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL basic_timeout: busy stuck high"); end
        compared++;
        if (cyc != done_at + 1) begin mismatched++; $display("FAIL basic_busy_drop: idle at %0d want %0d", cyc, done_at + 1); end
        compared++;
        if (hs_rnd.size() != N) begin mismatched++; $display("FAIL basic_hs_count: got %0d want %0d", hs_rnd.size(), N); end
        for (int i = 0; i < hs_rnd.size() && i < N; i++) begin
            compared++;
            if (hs_rnd[i] !== 7'(i + 1)) begin mismatched++; $display("FAIL basic_round: got %0d want %0d", hs_rnd[i], i + 1); end
            compared++;
            if (hs_key[i] !== exp_key(base, i + 1)) begin mismatched++; $display("FAIL basic_key r%0d: got %h want %h", i + 1, hs_key[i], exp_key(base, i + 1)); end
            if (i > 0) begin
                compared++;
                if (hs_cyc[i] - hs_cyc[i - 1] != 2 + S) begin mismatched++; $display("FAIL basic_latency: got %0d want %0d", hs_cyc[i] - hs_cyc[i - 1], 2 + S); end
            end
        end
        compared++;
        if (done_n != 1) begin mismatched++; $display("FAIL basic_done_count: got %0d want 1", done_n); end
        compared++;
        if (hs_cyc.size() == 0 || done_at != hs_cyc[$] + 1) begin mismatched++; $display("FAIL basic_done_timing: got %0d want one after last handshake", done_at); end
        compared++;
        if (strobes - s0 != P + N) begin mismatched++; $display("FAIL basic_strobes: got %0d want %0d", strobes - s0, P + N); end
        compared++;
        if (back_to_back != 0) begin mismatched++; $display("FAIL strobe_gap: got %0d back-to-back want 0", back_to_back); end
        exp_steps += P + N;
    endtask

    task automatic test_backpressure();
        bit ok, ok1, ok2;
        int base = exp_steps, s0 = strobes, s1;
        logic [23:0] snap;
        clear_logs();
        rk_ready = 1;
        pulse_start();
        wait_for(7'd2, 1'b0, ok1);
        @(posedge clk); #1 rk_ready = 0;
        wait_for(7'd2, 1'b1, ok2);
        snap = {rk0, rk1, rk2};
        s1 = strobes;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            compared++;
            if ({rk_valid, rk0, rk1, rk2} !== {1'b1, snap}) begin mismatched++; $display("FAIL bp_hold: got %h want %h", {rk_valid, rk0, rk1, rk2}, {1'b1, snap}); end
            compared++;
            if (strobes != s1) begin mismatched++; $display("FAIL bp_strobe: got %0d want %0d", strobes, s1); end
        end
        @(posedge clk); #1 rk_ready = 1;
        @(negedge clk); #1;
        compared++;
        if ({rk_valid, round_idx} !== {1'b1, 7'd2}) begin mismatched++; $display("FAIL bp_pre_hs: got %h want %h", {rk_valid, round_idx}, {1'b1, 7'd2}); end
        @(negedge clk); #1;
        compared++;
        if ({rk_valid, round_idx} !== {1'b0, 7'd3}) begin mismatched++; $display("FAIL bp_post_hs: got %h want %h", {rk_valid, round_idx}, {1'b0, 7'd3}); end
        wait_idle(ok);
        compared++;
        if (!(ok && ok1 && ok2)) begin mismatched++; $display("FAIL bp_timeout: waits %0d%0d%0d want 111", ok1, ok2, ok); end
        compared++;
        if (hs_rnd.size() != N) begin mismatched++; $display("FAIL bp_hs_count: got %0d want %0d", hs_rnd.size(), N); end
        for (int i = 0; i < hs_rnd.size() && i < N; i++) begin
            compared++;
            if ({hs_rnd[i], hs_key[i]} !== {7'(i + 1), exp_key(base, i + 1)}) begin mismatched++; $display("FAIL bp_key r%0d: got %h want %h", i + 1, {hs_rnd[i], hs_key[i]}, {7'(i + 1), exp_key(base, i + 1)}); end
        end
        compared++;
        if (strobes - s0 != P + N || done_n != 1) begin mismatched++; $display("FAIL bp_totals: strobes %0d done %0d want %0d 1", strobes - s0, done_n, P + N); end
        exp_steps += P + N;
    endtask

    task automatic test_abort();
        bit ok1, ok2;
        int base = exp_steps, s0 = strobes;
        logic [23:0] snap;
        clear_logs();
        rk_ready = 1;
        pulse_start();
        wait_for(7'd3, 1'b0, ok1);
        @(posedge clk); #1 rk_ready = 0;
        wait_for(7'd3, 1'b1, ok2);
        snap = {rk0, rk1, rk2};
        @(posedge clk); #1 abort = 1; rk_ready = 1;
        @(posedge clk); #1 abort = 0;
        @(negedge clk); #1;
        compared++;
        if ({busy, rk_valid, sched_step, done, round_idx} !== 11'h0) begin mismatched++; $display("FAIL abort_idle: got %h want 0", {busy, rk_valid, sched_step, done, round_idx}); end
        compared++;
        if ({rk0, rk1, rk2} !== snap) begin mismatched++; $display("FAIL abort_keys_kept: got %h want %h", {rk0, rk1, rk2}, snap); end
        repeat (4) @(negedge clk);
        #1;
        compared++;
        if (!(ok1 && ok2) || done_n != 0 || busy) begin mismatched++; $display("FAIL abort_no_done: done %0d busy %0d waits %0d%0d want 0 0 11", done_n, busy, ok1, ok2); end
        compared++;
        if (hs_rnd.size() != 2) begin mismatched++; $display("FAIL abort_hs_count: got %0d want 2", hs_rnd.size()); end
        for (int i = 0; i < hs_rnd.size() && i < 2; i++) begin
            compared++;
            if (hs_key[i] !== exp_key(base, i + 1)) begin mismatched++; $display("FAIL abort_key r%0d: got %h want %h", i + 1, hs_key[i], exp_key(base, i + 1)); end
        end
        compared++;
        if (strobes - s0 != P + 3) begin mismatched++; $display("FAIL abort_strobes: got %0d want %0d", strobes - s0, P + 3); end
        exp_steps += P + 3;
    endtask

    task automatic test_ignored_start();
        bit ok, saw_busy = 0;
        int s0 = strobes;
        clear_logs();
        rk_ready = 1;
        pulse_start();
        repeat (6) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1 start = 0;
        wait_idle(ok);
        compared++;
        if (!ok || hs_rnd.size() != N || done_n != 1) begin mismatched++; $display("FAIL busy_start: hs %0d done %0d idle %0d want %0d 1 1", hs_rnd.size(), done_n, ok, N); end
        compared++;
        if (strobes - s0 != P + N) begin mismatched++; $display("FAIL busy_start_strobes: got %0d want %0d", strobes - s0, P + N); end
        exp_steps += P + N;
        s0 = strobes;
        @(posedge clk); #1 start = 1; abort = 1;
        @(posedge clk); #1 start = 0; abort = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1 saw_busy |= busy;
        end
        compared++;
        if (saw_busy || strobes != s0) begin mismatched++; $display("FAIL start_abort_idle: busy %0d strobes %0d want 0 0", saw_busy, strobes - s0); end
    endtask

    task automatic test_rst_mid_settle();
        bit ok;
        int s0 = strobes;
        clear_logs();
        rk_ready = 1;
        pulse_start();
        wait_for(7'd1, 1'b0, ok);
        @(negedge clk);
        #2 rst = 1;
        #1;
        compared++;
        if ({sched_step, rk_valid, busy, done, round_idx, rk0, rk1, rk2} !== 35'h0) begin mismatched++; $display("FAIL rst_async: got %h want 0", {sched_step, rk_valid, busy, done, round_idx, rk0, rk1, rk2}); end
        @(posedge clk); #1 rst = 0;
        repeat (4) @(negedge clk);
        #1;
        compared++;
        if (!ok || done_n != 0 || busy || strobes - s0 != P + 1) begin mismatched++; $display("FAIL rst_after: done %0d busy %0d strobes %0d want 0 0 %0d", done_n, busy, strobes - s0, P + 1); end
        exp_steps += P + 1;
    endtask

    initial begin
        key = 8'($urandom);
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_basic();
        test_ignored_start();
        test_rst_mid_settle();
        test_basic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
